// File: rtl/arm7tdmi_pkg.sv
// ----------------------------------------------------------------------------
// arm7tdmi_pkg
//   Shared types for the ARM7TDMI execute-stage multiplier.
//   mul_op_t    : 3-bit operation descriptor {is_long, is_signed, accum}
//                 MUL=000 MLA=001 UMULL=100 UMLAL=101 SMULL=110 SMLAL=111
//   mul_state_t : multiplier FSM states
// ----------------------------------------------------------------------------
package arm7tdmi_pkg;

    typedef struct packed {
        logic is_long;
        logic is_signed;
        logic accum;
    } mul_op_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/arm7tdmi_mul_step.sv
// ----------------------------------------------------------------------------
// arm7tdmi_mul_step
//   Combinational single step of the iterative multiplier:
//     acc_o = acc_i + ((rm_ext_i * chunk_i) << shamt_i)
//                   - (correct_i ? rm_ext_i << (shamt_i + BITS_PER_CYCLE) : 0)
//   The chunk is always treated as unsigned; a negatively weighted Rs tail
//   (signed top chunk, or an all-ones remainder) is folded in through the
//   correction term.
// Ports:
//   acc_i     in  2*XLEN          running accumulator
//   rm_ext_i  in  2*XLEN          multiplicand, already sign/zero extended
//   chunk_i   in  BITS_PER_CYCLE  current Rs chunk
//   shamt_i   in  SHW             bit weight of the current chunk
//   correct_i in  1               subtract rm_ext_i weighted just above chunk
//   acc_o     out 2*XLEN          updated accumulator (mod 2^(2*XLEN))
// ----------------------------------------------------------------------------
module arm7tdmi_mul_step
    import arm7tdmi_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 8,
    parameter int SHW            = 6
) (
    input  logic [2*XLEN-1:0]         acc_i,
    input  logic [2*XLEN-1:0]         rm_ext_i,
    input  logic [BITS_PER_CYCLE-1:0] chunk_i,
    input  logic [SHW-1:0]            shamt_i,
    input  logic                      correct_i,
    output logic [2*XLEN-1:0]         acc_o
);

    logic [2*XLEN-1:0] partial;
    logic [2*XLEN-1:0] shifted;
    logic [2*XLEN-1:0] corr;

    always_comb begin
        partial = rm_ext_i * {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, chunk_i};
        shifted = partial << shamt_i;
        corr    = correct_i ? (rm_ext_i << (shamt_i + SHW'(BITS_PER_CYCLE))) : '0;
        acc_o   = acc_i + shifted - corr;
    end

endmodule

// File: rtl/arm7tdmi_mul_unit.sv
// ----------------------------------------------------------------------------
// arm7tdmi_mul_unit
//   Iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit for the ARM7TDMI execute
//   stage. Retires BITS_PER_CYCLE bits of Rs per CALC cycle.
//   FSM: IDLE -> CALC -> DONE -> IDLE. done_o pulses for the DONE cycle.
//   Optional feature macro: ARM7_MUL_EARLY_TERM_EN
//     When defined, CALC ends as soon as the unprocessed Rs bits are all zero
//     (or all one for signed ops). Results are identical, only latency shrinks.
// Ports:
//   clk, rst_n           clock / asynchronous active-low reset
//   flush_i              cancel the operation in flight (wins over start_i)
//   start_i, op_i        request and operation, sampled while ready_o=1
//   rm_i, rs_i           multiplicand / multiplier
//   rn_i, rdhi_i         accumulate low word / high word (long accumulate)
//   ready_o              unit idle
//   done_o               one-cycle result-valid pulse
//   res_lo_o, res_hi_o   result words (res_hi_o = 0 for short ops)
//   n_o, z_o             N/Z flags of the result
// ----------------------------------------------------------------------------
module arm7tdmi_mul_unit
    import arm7tdmi_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            start_i,
    input  mul_op_t         op_i,
    input  logic [XLEN-1:0] rm_i,
    input  logic [XLEN-1:0] rs_i,
    input  logic [XLEN-1:0] rn_i,
    input  logic [XLEN-1:0] rdhi_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [XLEN-1:0] res_lo_o,
    output logic [XLEN-1:0] res_hi_o,
    output logic            n_o,
    output logic            z_o
);

    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int SHW  = $clog2(2*XLEN);

`ifdef ARM7_MUL_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    mul_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              long_q, long_d;
    logic              signed_q, signed_d;
    logic [2*XLEN-1:0] rm_ext_q, rm_ext_d;
    logic [XLEN-1:0]   rs_q, rs_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   res_lo_q, res_lo_d;
    logic [XLEN-1:0]   res_hi_q, res_hi_d;
    logic              n_q, n_d;
    logic              z_q, z_d;
    logic              done_q, done_d;

    logic [SHW-1:0]            shamt;
    logic [SHW-1:0]            shamt_next;
    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [XLEN-1:0]           rs_sra;
    logic                      last_step;
    logic                      rem_zero;
    logic                      rem_ones;
    logic                      correct;
    logic                      finish;
    logic [2*XLEN-1:0]         acc_step;

    // Chunk selection and termination detect. The remainder checks look at
    // the Rs bits above the chunk being retired this cycle. On the final
    // chunk of a signed op the chunk's MSB carries negative weight, which is
    // expressed as an unsigned chunk plus a correction one chunk higher; an
    // all-ones signed remainder is the same -2^k correction.
    always_comb begin
        shamt      = SHW'(cnt_q) * SHW'(BITS_PER_CYCLE);
        shamt_next = shamt + SHW'(BITS_PER_CYCLE);
        chunk      = BITS_PER_CYCLE'(rs_q >> shamt);
        rs_sra     = $signed(rs_q) >>> shamt_next;
        last_step  = (cnt_q == CW'(ITER-1));
        rem_zero   = ((rs_q >> shamt_next) == '0);
        rem_ones   = &rs_sra;
        if (last_step) begin
            correct = signed_q & chunk[BITS_PER_CYCLE-1];
            finish  = 1'b1;
        end else begin
            correct = EARLY_TERM & signed_q & rem_ones & ~rem_zero;
            finish  = EARLY_TERM & (rem_zero | (signed_q & rem_ones));
        end
    end

    arm7tdmi_mul_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHW            (SHW)
    ) u_step (
        .acc_i     (acc_q),
        .rm_ext_i  (rm_ext_q),
        .chunk_i   (chunk),
        .shamt_i   (shamt),
        .correct_i (correct),
        .acc_o     (acc_step)
    );

    // Next-state logic. Outputs and flags only change on the CALC -> DONE
    // transition, so a flush leaves the previous result visible.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        long_d   = long_q;
        signed_d = signed_q;
        rm_ext_d = rm_ext_q;
        rs_d     = rs_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        n_d      = n_q;
        z_d      = z_q;
        done_d   = 1'b0;

        case (state_q)
            MUL_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d  = MUL_CALC;
                    cnt_d    = '0;
                    long_d   = op_i.is_long;
                    signed_d = op_i.is_signed;
                    rs_d     = rs_i;
                    rm_ext_d = op_i.is_signed ? {{XLEN{rm_i[XLEN-1]}}, rm_i}
                                              : {{XLEN{1'b0}}, rm_i};
                    if (!op_i.accum) begin
                        acc_d = '0;
                    end else if (op_i.is_long) begin
                        acc_d = {rdhi_i, rn_i};
                    end else begin
                        acc_d = {{XLEN{1'b0}}, rn_i};
                    end
                end
            end
            MUL_CALC: begin
                if (flush_i) begin
                    state_d = MUL_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (finish) begin
                        state_d  = MUL_DONE;
                        done_d   = 1'b1;
                        res_lo_d = acc_step[XLEN-1:0];
                        if (long_q) begin
                            res_hi_d = acc_step[2*XLEN-1:XLEN];
                            n_d      = acc_step[2*XLEN-1];
                            z_d      = (acc_step == '0);
                        end else begin
                            res_hi_d = '0;
                            n_d      = acc_step[XLEN-1];
                            z_d      = (acc_step[XLEN-1:0] == '0);
                        end
                    end
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            long_q   <= 1'b0;
            signed_q <= 1'b0;
            rm_ext_q <= '0;
            rs_q     <= '0;
            acc_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            long_q   <= long_d;
            signed_q <= signed_d;
            rm_ext_q <= rm_ext_d;
            rs_q     <= rs_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            n_q      <= n_d;
            z_q      <= z_d;
            done_q   <= done_d;
        end
    end

    assign ready_o  = (state_q == MUL_IDLE);
    assign done_o   = done_q;
    assign res_lo_o = res_lo_q;
    assign res_hi_o = res_hi_q;
    assign n_o      = n_q;
    assign z_o      = z_q;

endmodule

// File: tb/tb_arm7tdmi_mul_unit.sv
// ----------------------------------------------------------------------------
// tb_arm7tdmi_mul_unit
//   Scoreboard bench for arm7tdmi_mul_unit (XLEN=32, BITS_PER_CYCLE=8).
//   Expected results and latencies are computed from a direct 64-bit
//   multiply model when a request is issued and popped when done_o fires.
//   Latency expectations follow ARM7_MUL_EARLY_TERM_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_arm7tdmi_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rm_i;
    logic [31:0] rs_i;
    logic [31:0] rn_i;
    logic [31:0] rdhi_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] res_lo_o;
    logic [31:0] res_hi_o;
    logic        n_o;
    logic        z_o;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        n;
        logic        z;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] rn;
        logic [31:0] rdhi;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    arm7tdmi_mul_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rm_i     (rm_i),
        .rs_i     (rs_i),
        .rn_i     (rn_i),
        .rdhi_i   (rdhi_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .res_lo_o (res_lo_o),
        .res_hi_o (res_hi_o),
        .n_o      (n_o),
        .z_o      (z_o)
    );

    // Reference: full-width product plus accumulator, truncated to 64 bits.
    // Latency is the smallest chunk count after which the rest of Rs is a
    // pure sign/zero extension (early termination), otherwise 4 steps.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] rm,
                                   input logic [31:0] rs, input logic [31:0] rn,
                                   input logic [31:0] rdhi);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] acc;
        logic [63:0] r;
        logic [31:0] mask;
        exp_t        e;
        int          steps;
        a   = op[1] ? {{32{rm[31]}}, rm} : {32'b0, rm};
        b   = op[1] ? {{32{rs[31]}}, rs} : {32'b0, rs};
        acc = !op[0] ? 64'd0 : (op[2] ? {rdhi, rn} : {32'b0, rn});
        r   = a * b + acc;
        e.lo = r[31:0];
        if (op[2]) begin
            e.hi = r[63:32];
            e.n  = r[63];
            e.z  = (r == 64'd0);
        end else begin
            e.hi = 32'd0;
            e.n  = r[31];
            e.z  = (r[31:0] == 32'd0);
        end
        steps = 4;
`ifdef ARM7_MUL_EARLY_TERM_EN
        for (int k = 3; k >= 1; k--) begin
            mask = 32'hFFFF_FFFF << (8*k);
            if ((rs & mask) == 32'd0 || (op[1] && (rs & mask) == mask)) steps = k;
        end
`else
        mask = 32'd0;
`endif
        e.lat = steps + 1;
        return e;
    endfunction

    // Waits for ready, drives one request for one edge and records the
    // expected result. Returns at cycle 1 (one cycle after acceptance).
    task automatic issue(input logic [2:0] op, input logic [31:0] rm, input logic [31:0] rs,
                         input logic [31:0] rn, input logic [31:0] rdhi);
        int w = 0;
        while (!ready_o && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!ready_o) begin
            checks++; errors++;
            $display("[TB] FAIL issue_ready: ready_o=%0b required 1", ready_o);
        end
        op_i = op; rm_i = rm; rs_i = rs; rn_i = rn; rdhi_i = rdhi;
        start_i = 1'b1;
        sb.push_back(model(op, rm, rs, rn, rdhi));
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Cycle index (relative to acceptance) at which done_o is seen, -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done_o && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done_o) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; start_i = 1'b0;
        op_i = 3'd0; rm_i = '0; rs_i = '0; rn_i = '0; rdhi_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: ready=%0b done=%0b required ready=1 done=0", ready_o, done_o);
        end
        checks++;
        if (res_lo_o !== 32'd0 || res_hi_o !== 32'd0 || n_o !== 1'b0 || z_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: lo=%h hi=%h n=%0b z=%0b required all 0",
                     res_lo_o, res_hi_o, n_o, z_o);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        vec_t v[16];
        exp_t e;
        int   cyc;
        v[0] = '{3'b000, 32'd7,         32'd6,         32'd0, 32'd0};
        v[1] = '{3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        v[2] = '{3'b110, 32'hFFFF_FFFE, 32'd3,         32'd0, 32'd0};
        v[3] = '{3'b111, 32'h0001_0000, 32'hFFFF_FFFF, 32'd5, 32'd0};
        v[4] = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[5] = '{3'b110, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0};
        v[6] = '{3'b001, 32'd3,         32'hFFFF_FF80, 32'd1, 32'd0};
        v[7] = '{3'b000, 32'h1234_5678, 32'h0001_0000, 32'd0, 32'd0};
        for (int i = 8; i < 16; i++) begin
            v[i] = '{3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom};
            if (i[0]) v[i].rs = v[i].rs >> (8 * $urandom_range(0, 3));
        end
        for (int i = 0; i < 16; i++) begin
            issue(v[i].op, v[i].rm, v[i].rs, v[i].rn, v[i].rdhi);
            wait_done(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc != e.lat) begin
                errors++;
                $display("[TB] FAIL arith_latency[%0d]: done at cycle %0d, required %0d", i, cyc, e.lat);
            end
            if (cyc < 0) continue;
            checks++;
            if (res_lo_o !== e.lo || res_hi_o !== e.hi) begin
                errors++;
                $display("[TB] FAIL arith_result[%0d]: got %h_%h, required %h_%h",
                         i, res_hi_o, res_lo_o, e.hi, e.lo);
            end
            checks++;
            if (n_o !== e.n || z_o !== e.z) begin
                errors++;
                $display("[TB] FAIL arith_flags[%0d]: n=%0b z=%0b, required n=%0b z=%0b",
                         i, n_o, z_o, e.n, e.z);
            end
            @(posedge clk); #1;
            checks++;
            if (done_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("[TB] FAIL arith_pulse[%0d]: done=%0b ready=%0b after DONE, required 0/1",
                         i, done_o, ready_o);
            end
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   dones = 0;
        issue(3'b001, 32'd0, 32'd0, 32'd0, 32'd0);
        start_i = 1'b1;
        e = sb.pop_front();
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_ready: ready_o=%0b in CALC, required 0", ready_o);
        end
        for (int c = 0; c < 14; c++) begin
            if (done_o) begin
                dones++;
                start_i = 1'b0;
                checks++;
                if (res_lo_o !== e.lo || z_o !== 1'b1 || n_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mla_zero: lo=%h z=%0b n=%0b, required lo=0 z=1 n=0",
                             res_lo_o, z_o, n_o);
                end
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        checks++;
        if (dones != 1) begin
            errors++;
            $display("[TB] FAIL start_ignored: %0d done pulses, required 1", dones);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        int   cyc;
        int   dones = 0;
        issue(3'b000, 32'd7, 32'd6, 32'd0, 32'd0);
        wait_done(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc < 0 || res_lo_o !== 32'd42) begin
            errors++;
            $display("[TB] FAIL flush_setup: lo=%h cyc=%0d, required lo=0000002a", res_lo_o, cyc);
        end
        @(posedge clk); #1;
        issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_ready: ready_o=%0b after flush, required 1", ready_o);
        end
        // Flush must also win over a simultaneous start in IDLE.
        start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done_o || !ready_o) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("[TB] FAIL flush_quiet: %0d busy/done cycles, required 0", dones);
        end
        checks++;
        if (res_lo_o !== e.lo || res_hi_o !== e.hi || n_o !== e.n || z_o !== e.z) begin
            errors++;
            $display("[TB] FAIL flush_hold: got %h_%h n=%0b z=%0b, required %h_%h n=%0b z=%0b",
                     res_hi_o, res_lo_o, n_o, z_o, e.hi, e.lo, e.n, e.z);
        end
    endtask

    task automatic test_async_reset();
        issue(3'b111, 32'h0001_0000, 32'h7FFF_FFFF, 32'd5, 32'd9);
        void'(sb.pop_back());
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || done_o !== 1'b0 || res_lo_o !== 32'd0 ||
            res_hi_o !== 32'd0 || n_o !== 1'b0 || z_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: ready=%0b done=%0b lo=%h hi=%h n=%0b z=%0b, required 1 0 0 0 0 0",
                     ready_o, done_o, res_lo_o, res_hi_o, n_o, z_o);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        for (int i = 0; i < 6; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom, $urandom >> (8 * (i % 4)), $urandom, $urandom);
            wait_done(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc != e.lat || res_lo_o !== e.lo || res_hi_o !== e.hi ||
                n_o !== e.n || z_o !== e.z) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]: cyc=%0d %h_%h n=%0b z=%0b, required cyc=%0d %h_%h n=%0b z=%0b",
                         i, cyc, res_hi_o, res_lo_o, n_o, z_o, e.lat, e.hi, e.lo, e.n, e.z);
            end
            if (cyc >= 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_arith();
        test_start_ignored();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
